// File: rtl/sr_btn_pulse_gen.sv
// Debounces two asynchronous push buttons and turns each clean press into one
// single-cycle s or r pulse for the SR flip-flop; simultaneous presses raise conflict.
module sr_btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_clr,
  output logic s,
  output logic r,
  output logic conflict
);

  // state     | meaning
  // IDLE      | both debounced buttons low, waiting for a press
  // PULSE_S   | one-cycle set pulse on s
  // PULSE_R   | one-cycle clear pulse on r
  // WAIT_REL  | pulse issued, waiting for both buttons released
  // CONFLICT  | both pressed together, held until both released

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PULSE_S  = 3'd1,
    PULSE_R  = 3'd2,
    WAIT_REL = 3'd3,
    CONFLICT = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Channel 0 is the set button, channel 1 the clear button.
  logic [1:0]    sync1, sync2, stable;
  logic [CW-1:0] cnt [2];
  logic          ds, dc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_clr, btn_set};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        stable[i] <= 1'b0;
        cnt[i]    <= '0;
      end else if (sync2[i] == stable[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable[i] <= sync2[i];
        cnt[i]    <= '0;
      end else begin
        cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  assign ds = stable[0];
  assign dc = stable[1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ds && dc) state_nxt = CONFLICT;
        else if (ds)  state_nxt = PULSE_S;
        else if (dc)  state_nxt = PULSE_R;
      end
      PULSE_S,
      PULSE_R:  state_nxt = WAIT_REL;
      WAIT_REL,
      CONFLICT: if (!ds && !dc) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s        = (state == PULSE_S);
    r        = (state == PULSE_R);
    conflict = (state == CONFLICT);
  end

endmodule

// File: tb/tb_sr_btn_pulse_gen.sv
// Directed bench for sr_btn_pulse_gen (D=4): press latency, bounce rejection,
// conflict handling, staggered presses and reset while a button is held.
module tb_sr_btn_pulse_gen;

  logic clk = 1'b0;
  logic reset, btn_set, btn_clr;
  logic s, r, conflict;

  int checks = 0;
  int failures = 0;

  int ns, nr, nc, fs, fr, fc, idx;
  logic clog [64];

  sr_btn_pulse_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_set  (btn_set),
    .btn_clr  (btn_clr),
    .s        (s),
    .r        (r),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    ns = 0; nr = 0; nc = 0;
    fs = -1; fr = -1; fc = -1;
    idx = 0;
  endtask

  // Advance n cycles; outputs are sampled on the falling edge after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (idx < 64) clog[idx] = conflict;
      if (s) begin ns++; if (fs < 0) fs = idx; end
      if (r) begin nr++; if (fr < 0) fr = idx; end
      if (conflict) begin nc++; if (fc < 0) fc = idx; end
      chk("onehot0", int'($onehot0({s, r, conflict})), 1);
      idx++;
    end
  endtask

  initial begin
    reset = 1'b1; btn_set = 1'b0; btn_clr = 1'b0;
    @(negedge clk);

    // 1. reset values
    clear_log();
    run(2);
    chk("rst_s", int'(s), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_conflict", int'(conflict), 0);
    reset = 1'b0;
    run(3);
    chk("idle_quiet", ns + nr + nc, 0);

    // 2. clean set press, 20-cycle hold
    clear_log();
    btn_set = 1'b1;
    run(20);
    chk("set_pulse_cnt", ns, 1);
    chk("set_pulse_idx", fs, 6);
    chk("set_no_r", nr, 0);
    chk("set_no_conflict", nc, 0);
    clear_log();
    btn_set = 1'b0;
    run(10);
    chk("set_release_quiet", ns + nr + nc, 0);

    // 3. bounce rejection on clear, then a clean hold
    clear_log();
    for (int i = 0; i < 6; i++) begin
      btn_clr = (i % 2 == 0);
      run(1);
    end
    btn_clr = 1'b0;
    run(8);
    chk("bounce_no_r", nr, 0);
    chk("bounce_no_other", ns + nc, 0);
    clear_log();
    btn_clr = 1'b1;
    run(10);
    chk("clr_pulse_cnt", nr, 1);
    chk("clr_pulse_idx", fr, 6);
    chk("clr_no_s", ns, 0);
    btn_clr = 1'b0;
    run(10);

    // 4. simultaneous press
    clear_log();
    btn_set = 1'b1; btn_clr = 1'b1;
    run(10);
    chk("conf_first_idx", fc, 6);
    chk("conf_before", int'(clog[5]), 0);
    chk("conf_held", int'(clog[9]), 1);
    chk("conf_no_sr", ns + nr, 0);
    clear_log();
    btn_set = 1'b0;
    run(10);
    chk("conf_one_released", nc, 10);
    chk("conf_one_rel_no_sr", ns + nr, 0);
    clear_log();
    btn_clr = 1'b0;
    run(10);
    chk("conf_rel_still", int'(clog[5]), 1);
    chk("conf_rel_cleared", int'(clog[6]), 0);
    chk("conf_rel_len", nc, 6);

    // 5. staggered press: set wins, clear swallowed
    clear_log();
    btn_set = 1'b1;
    run(3);
    chk("stag_early_quiet", ns + nr + nc, 0);
    clear_log();
    btn_clr = 1'b1;
    run(12);
    chk("stag_s_cnt", ns, 1);
    chk("stag_s_idx", fs, 3);
    chk("stag_no_r", nr, 0);
    chk("stag_no_conflict", nc, 0);
    clear_log();
    btn_set = 1'b0; btn_clr = 1'b0;
    run(10);
    chk("stag_release_quiet", ns + nr + nc, 0);
    clear_log();
    btn_clr = 1'b1;
    run(10);
    chk("stag_clr_cnt", nr, 1);
    chk("stag_clr_idx", fr, 6);
    btn_clr = 1'b0;
    run(10);

    // 6. reset while set is held
    clear_log();
    btn_set = 1'b1;
    run(10);
    chk("mid_first_s", ns, 1);
    chk("mid_first_idx", fs, 6);
    clear_log();
    reset = 1'b1;
    run(1);
    chk("mid_rst_out", ns + nr + nc, 0);
    reset = 1'b0;
    clear_log();
    run(12);
    chk("mid_second_s", ns, 1);
    chk("mid_second_idx", fs, 6);
    chk("mid_no_r", nr + nc, 0);
    btn_set = 1'b0;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
